regfile_wb_scheduler: RTL and testbench

- Shares the single register-file write port between two writeback requesters: port 0 (ALU pipeline) and port 1 (long-latency unit, load/MDU).
- Keeps a per-register pending-write scoreboard, so issue logic can stall RAW and WAW hazards.
- Sits between the execute/memory stages and the 32x32 register file. Drives its regwrite/write-address/write-data inputs from registered outputs.

---
 rtl/regfile_wb_scheduler_pkg.sv | 11 +
 rtl/regfile_wb_arbiter.sv | 23 ++
 rtl/regfile_wb_scheduler.sv | 66 ++++++
 tb/tb_regfile_wb_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared widths, x0 constant and writeback request struct
package regfile_wb_scheduler_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: port0-priority writeback grant with port1 starvation override (clk, reset, wb0/wb1 valid in, gnt0/gnt1 out)
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wb0_valid,
  input  logic wb1_valid,
  output logic gnt0,
  output logic gnt1
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  logic [CW-1:0] starve_cnt;
  always_comb begin
    gnt1 = !reset && wb1_valid && (!wb0_valid || starve_cnt == SMAX);
    gnt0 = !reset && wb0_valid && !gnt1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_cnt <= '0;
    else if (!wb1_valid || gnt1) starve_cnt <= '0;
    else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates two writeback ports onto the registered regfile write port and tracks pending writes (issue/rs queries in, busy/ready and rf_* out)
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             wb0_valid,
  input  logic [4:0]       wb0_rd,
  input  logic [XLEN-1:0]  wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [4:0]       wb1_rd,
  input  logic [XLEN-1:0]  wb1_data,
  output logic             wb1_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREGS-1:0] pending
);
  import regfile_wb_scheduler_pkg::*;
  logic gnt0, gnt1;
  wb_req_t sel;
  logic [NREGS-1:0] set_mask, clr_mask;
  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk(clk),
    .reset(reset),
    .wb0_valid(wb0_valid),
    .wb1_valid(wb1_valid),
    .gnt0(gnt0),
    .gnt1(gnt1)
  );
  always_comb begin
    wb0_ready = gnt0;
    wb1_ready = gnt1;
    sel = gnt1 ? wb_req_t'{1'b1, wb1_rd, wb1_data} : wb_req_t'{gnt0, wb0_rd, wb0_data};
    rs1_busy = pending[rs1_addr];
    rs2_busy = pending[rs2_addr];
    issue_ready = !reset && !(pending[issue_rd] && issue_rd != REG_X0);
    set_mask = (issue_valid && issue_ready && issue_rd != REG_X0) ? NREGS'(1) << issue_rd : '0;
    clr_mask = (rf_we && pending[rf_waddr]) ? NREGS'(1) << rf_waddr : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= REG_X0;
      rf_wdata <= '0;
      pending  <= '0;
    end else begin
      rf_we   <= sel.valid && sel.rd != REG_X0;
      pending <= (pending & ~clr_mask) | set_mask;
      if (sel.valid) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  assert property (@(posedge clk) disable iff (reset) rf_we |-> pending[rf_waddr]);
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: scoreboard-checked bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic issue_ready;
  logic [4:0] rs1_addr = '0, rs2_addr = '0;
  logic rs1_busy, rs2_busy;
  logic wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [4:0] wb0_rd = '0, wb1_rd = '0;
  logic [31:0] wb0_data = '0, wb1_data = '0;
  logic wb0_ready, wb1_ready;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  regfile_wb_scheduler #(.XLEN(32), .NREGS(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );
  always #5 clk = ~clk;
  always begin
    @(negedge clk);
    #3;
    if (reset) q.delete();
    else begin
      checks++;
      if (q.size() == 0) begin
        if (rf_we !== 1'b0) begin errors++; $display("FAIL mon_spurious_we: rf_we=%b required 0", rf_we); end
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL mon_write: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h", rf_we, rf_waddr, rf_wdata, e.rd, e.data);
        end
      end
      checks++;
      if (wb0_ready && wb1_ready) begin errors++; $display("FAIL mon_one_grant: wb0_ready=1 wb1_ready=1 required at most one"); end
      if (wb0_valid && wb0_ready && wb0_rd != 5'd0) q.push_back({wb0_rd, wb0_data});
      if (wb1_valid && wb1_ready && wb1_rd != 5'd0) q.push_back({wb1_rd, wb1_data});
    end
  end
  task automatic issue(input logic [4:0] rd);
    @(negedge clk); issue_valid = 1'b1; issue_rd = rd;
    @(negedge clk); issue_valid = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    wb0_valid = 1'b1; wb1_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    checks += 6;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: %b required 0", rf_we); end
    if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: %0d required 0", rf_waddr); end
    if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: %h required 0", rf_wdata); end
    if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: %h required 0", pending); end
    if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin errors++; $display("FAIL reset_wb_ready: %b%b required 00", wb0_ready, wb1_ready); end
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: %b required 0", issue_ready); end
    @(negedge clk);
    reset = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0; issue_valid = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_reset_issue_ready: %b required 1", issue_ready); end
  endtask
  task automatic test_single;
    issue(5'd5);
    rs1_addr = 5'd5; rs2_addr = 5'd0; issue_rd = 5'd5;
    #1;
    checks += 3;
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_set: %b required 1", rs1_busy); end
    if (rs2_busy !== 1'b0) begin errors++; $display("FAIL single_x0_busy: %b required 0", rs2_busy); end
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL single_waw: issue_ready=%b required 0", issue_ready); end
    @(negedge clk); wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (wb0_ready !== 1'b1) begin errors++; $display("FAIL single_grant: %b required 1", wb0_ready); end
    @(negedge clk); wb0_valid = 1'b0;
    #1;
    checks += 4;
    if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we: %b required 1", rf_we); end
    if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr: %0d required 5", rf_waddr); end
    if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata: %h required deadbeef", rf_wdata); end
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: %b required 1", rs1_busy); end
    @(negedge clk);
    #1;
    checks += 2;
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear: %b required 0", rs1_busy); end
    if (pending !== 32'd0) begin errors++; $display("FAIL single_pending: %h required 0", pending); end
  endtask
  task automatic test_priority_starve;
    for (int r = 10; r <= 16; r++) issue(5'(r));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wb0_valid = 1'b1;
      wb0_rd = (k < 4) ? 5'(10 + k) : 5'd15;
      wb0_data = 32'hA000_0000 | 32'(wb0_rd);
      wb1_valid = 1'b1;
      wb1_rd = (k < 5) ? 5'd14 : 5'd16;
      wb1_data = 32'hB000_0000 | 32'(wb1_rd);
      #1;
      checks += 2;
      if (wb0_ready !== (k != 4)) begin errors++; $display("FAIL starve_wb0_ready[%0d]: %b required %b", k, wb0_ready, k != 4); end
      if (wb1_ready !== (k == 4)) begin errors++; $display("FAIL starve_wb1_ready[%0d]: %b required %b", k, wb1_ready, k == 4); end
    end
    @(negedge clk); wb0_valid = 1'b0;
    #1;
    checks++;
    if (wb1_ready !== 1'b1) begin errors++; $display("FAIL starve_wb1_alone: %b required 1", wb1_ready); end
    @(negedge clk); wb1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (pending !== 32'd0) begin errors++; $display("FAIL starve_pending: %h required 0", pending); end
  endtask
  task automatic test_x0;
    logic [31:0] p;
    p = pending;
    @(negedge clk); wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234;
    #1;
    checks++;
    if (wb1_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: %b required 1", wb1_ready); end
    @(negedge clk); wb1_valid = 1'b0;
    #1;
    checks += 4;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: %b required 0", rf_we); end
    if (pending !== p) begin errors++; $display("FAIL x0_pending: %h required %h", pending, p); end
    if (rf_waddr !== 5'd0) begin errors++; $display("FAIL x0_waddr: %0d required 0", rf_waddr); end
    if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL x0_wdata: %h required 1234", rf_wdata); end
  endtask
  task automatic test_same_edge;
    issue(5'd7);
    @(negedge clk); wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h77;
    #1;
    checks++;
    if (wb1_ready !== 1'b1) begin errors++; $display("FAIL same_grant: %b required 1", wb1_ready); end
    @(negedge clk); wb1_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks += 2;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL same_commit: we=%b addr=%0d required we=1 addr=7", rf_we, rf_waddr); end
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL same_waw: issue_ready=%b required 0", issue_ready); end
    @(negedge clk);
    #1;
    checks += 2;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_retry_ready: %b required 1", issue_ready); end
    if (pending[7] !== 1'b0) begin errors++; $display("FAIL same_cleared: pending[7]=%b required 0", pending[7]); end
    @(negedge clk); issue_valid = 1'b0;
    #1;
    checks++;
    if (pending[7] !== 1'b1) begin errors++; $display("FAIL same_reissued: pending[7]=%b required 1", pending[7]); end
    @(negedge clk); wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h777;
    #1;
    checks++;
    if (wb0_ready !== 1'b1) begin errors++; $display("FAIL same_final_grant: %b required 1", wb0_ready); end
    @(negedge clk); wb0_valid = 1'b0;
  endtask
  task automatic test_idle;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks += 3;
      if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we: %b required 0", rf_we); end
      if (rf_waddr !== 5'd7) begin errors++; $display("FAIL idle_waddr: %0d required 7", rf_waddr); end
      if (rf_wdata !== 32'h777) begin errors++; $display("FAIL idle_wdata: %h required 777", rf_wdata); end
    end
  endtask
  task automatic test_reset_mid;
    issue(5'd1);
    issue(5'd2);
    #1;
    checks++;
    if (pending !== 32'h6) begin errors++; $display("FAIL rmid_pending_pre: %h required 6", pending); end
    @(negedge clk); wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h11; issue_rd = 5'd3;
    #1;
    checks++;
    if (wb0_ready !== 1'b1) begin errors++; $display("FAIL rmid_grant: %b required 1", wb0_ready); end
    reset = 1'b1;
    #1;
    checks += 4;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we: %b required 0", rf_we); end
    if (pending !== 32'd0) begin errors++; $display("FAIL rmid_pending: %h required 0", pending); end
    if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: %b%b required 00", wb0_ready, wb1_ready); end
    if (issue_ready !== 1'b0) begin errors++; $display("FAIL rmid_issue_ready: %b required 0", issue_ready); end
    @(negedge clk);
    @(negedge clk); reset = 1'b0; wb0_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      checks += 2;
      if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_no_write: %b required 0", rf_we); end
      if (pending !== 32'd0) begin errors++; $display("FAIL rmid_pending_post: %h required 0", pending); end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_priority_starve;
    test_x0;
    test_same_edge;
    test_idle;
    test_reset_mid;
    @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d outstanding required 0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
